// File: rtl/hnf_mshr_wakeup_ctl_if.sv
// Handshake bundle for the MSHR sleep/wakeup controller.
// Sizing comes from `HNF_PARAM (N = `MSHR_ENTRIES_NUM, W = `MSHR_ENTRIES_WIDTH).
// The master side drives the hazard/retire/ready signals; the slave side is the controller.

`ifndef MSHR_ENTRIES_NUM
`define MSHR_ENTRIES_NUM 8
`endif
`ifndef MSHR_ENTRIES_WIDTH
`define MSHR_ENTRIES_WIDTH 3
`endif
`ifndef HNF_PARAM
`define HNF_PARAM parameter int unsigned N = `MSHR_ENTRIES_NUM, parameter int unsigned W = `MSHR_ENTRIES_WIDTH
`endif

interface hnf_mshr_wakeup_ctl_if #(`HNF_PARAM);
    logic         mshr_alloc_en_s1_q;
    logic [W-1:0] mshr_entry_idx_alloc_s1_q;
    logic         rxreq_cam_hazard_s1_q;
    logic [N-1:0] rxreq_cam_hazard_entry_s1_q;
    logic         mshr_l3_hazard_valid_sx3_q;
    logic [N-1:0] pipe_cam_hazard_entry_sx3_q;
    logic [N-1:0] pipe_sleep_entry_sx3_q;
    logic         mshr_dbf_retired_valid_sx1_q;
    logic [W-1:0] mshr_dbf_retired_idx_sx1_q;
    logic         pipe_wakeup_ready_sx1;
    logic [N-1:0] mshr_sleep_entry_q;
    logic         mshr_wakeup_valid_sx1_q;
    logic [W-1:0] mshr_wakeup_idx_sx1_q;

    modport master (
        output mshr_alloc_en_s1_q, mshr_entry_idx_alloc_s1_q,
        output rxreq_cam_hazard_s1_q, rxreq_cam_hazard_entry_s1_q,
        output mshr_l3_hazard_valid_sx3_q, pipe_cam_hazard_entry_sx3_q, pipe_sleep_entry_sx3_q,
        output mshr_dbf_retired_valid_sx1_q, mshr_dbf_retired_idx_sx1_q, pipe_wakeup_ready_sx1,
        input  mshr_sleep_entry_q, mshr_wakeup_valid_sx1_q, mshr_wakeup_idx_sx1_q
    );

    modport slave (
        input  mshr_alloc_en_s1_q, mshr_entry_idx_alloc_s1_q,
        input  rxreq_cam_hazard_s1_q, rxreq_cam_hazard_entry_s1_q,
        input  mshr_l3_hazard_valid_sx3_q, pipe_cam_hazard_entry_sx3_q, pipe_sleep_entry_sx3_q,
        input  mshr_dbf_retired_valid_sx1_q, mshr_dbf_retired_idx_sx1_q, pipe_wakeup_ready_sx1,
        output mshr_sleep_entry_q, mshr_wakeup_valid_sx1_q, mshr_wakeup_idx_sx1_q
    );
endinterface

// File: rtl/hnf_mshr_wakeup_ctl.sv
// MSHR sleep/wakeup controller: entries that hit a live blocker go to sleep, wake to a
// pending state when the blocker retires, and are re-offered to the pipeline one per cycle.
// Optional feature macro: HNF_MSHR_WAKEUP_RR_EN selects round-robin wakeup arbitration;
// without it the lowest pending index wins and no pointer exists.

`ifndef MSHR_ENTRIES_NUM
`define MSHR_ENTRIES_NUM 8
`endif
`ifndef MSHR_ENTRIES_WIDTH
`define MSHR_ENTRIES_WIDTH 3
`endif
`ifndef HNF_PARAM
`define HNF_PARAM parameter int unsigned N = `MSHR_ENTRIES_NUM, parameter int unsigned W = `MSHR_ENTRIES_WIDTH
`endif

module hnf_mshr_wakeup_ctl #(`HNF_PARAM) (
    input  logic                  clk,
    input  logic                  rst,
    hnf_mshr_wakeup_ctl_if.slave  io_bus
);

    function automatic logic [W-1:0] f_enc(input logic [N-1:0] oh);
        logic [W-1:0] b;
        b = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) b = b | W'(i);
        end
        return b;
    endfunction

    logic [N-1:0] r_sleep, w_sleep_d;
    logic [N-1:0] r_pend, w_pend_d;
    logic [W-1:0] r_wait [N];
    logic [W-1:0] w_wait_d [N];
    logic         r_valid, w_valid_d;
    logic [W-1:0] r_idx, w_idx_d;

    logic         w_ret;
    logic [W-1:0] w_ret_idx;
    logic [N-1:0] w_ret_oh;
    logic         w_accept;
    logic [N-1:0] w_acc_oh;
    logic         w_a_en, w_p_en;
    logic [W-1:0] w_a_idx, w_a_blk, w_p_idx, w_p_blk;
    logic [N-1:0] w_req;
    logic [W-1:0] w_blk [N];
    logic [N-1:0] w_cand;
    logic         w_found;
    logic [W-1:0] w_sel;

`ifdef HNF_MSHR_WAKEUP_RR_EN
    logic [W-1:0] r_ptr, w_ptr_d;
    logic [W-1:0] w_idx_inc;
    logic [W-1:0] w_start;
    logic [N-1:0] w_rot;
`endif

    assign w_ret     = io_bus.mshr_dbf_retired_valid_sx1_q;
    assign w_ret_idx = io_bus.mshr_dbf_retired_idx_sx1_q;
    assign w_ret_oh  = w_ret ? (N'(1) << w_ret_idx) : '0;
    assign w_accept  = r_valid & io_bus.pipe_wakeup_ready_sx1;
    assign w_acc_oh  = w_accept ? (N'(1) << r_idx) : '0;

    assign w_a_en  = io_bus.mshr_alloc_en_s1_q & io_bus.rxreq_cam_hazard_s1_q;
    assign w_a_idx = io_bus.mshr_entry_idx_alloc_s1_q;
    assign w_a_blk = f_enc(io_bus.rxreq_cam_hazard_entry_s1_q);
    assign w_p_en  = io_bus.mshr_l3_hazard_valid_sx3_q;
    assign w_p_idx = f_enc(io_bus.pipe_sleep_entry_sx3_q);
    assign w_p_blk = f_enc(io_bus.pipe_cam_hazard_entry_sx3_q);

    // Per-entry sleep request; the allocation path overrides the pipeline path on a clash.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_req[i] = 1'b0;
            w_blk[i] = '0;
            if (w_p_en && w_p_idx == W'(i)) begin
                w_req[i] = 1'b1;
                w_blk[i] = w_p_blk;
            end
            if (w_a_en && w_a_idx == W'(i)) begin
                w_req[i] = 1'b1;
                w_blk[i] = w_a_blk;
            end
        end
    end

    // Next sleep/pending/wait state; later statements take priority, own-retire last.
    always_comb begin
        w_sleep_d = r_sleep;
        w_pend_d  = r_pend;
        for (int i = 0; i < N; i++) begin
            w_wait_d[i] = r_wait[i];
            if (w_acc_oh[i]) w_pend_d[i] = 1'b0;
            if (r_sleep[i] && w_ret && r_wait[i] == w_ret_idx) begin
                w_sleep_d[i] = 1'b0;
                w_pend_d[i]  = 1'b1;
            end
            if (w_req[i]) begin
                // Blocker already gone this cycle: go straight to pending.
                if (w_ret && w_blk[i] == w_ret_idx) begin
                    w_pend_d[i] = 1'b1;
                end else begin
                    w_sleep_d[i] = 1'b1;
                    w_wait_d[i]  = w_blk[i];
                end
            end
            if (w_ret_oh[i]) begin
                w_sleep_d[i] = 1'b0;
                w_pend_d[i]  = 1'b0;
            end
        end
    end

    // Candidates exclude the entry accepted now and any entry retiring now.
    assign w_cand = r_pend & ~w_acc_oh & ~w_ret_oh;

`ifdef HNF_MSHR_WAKEUP_RR_EN
    assign w_idx_inc = (r_idx == W'(N - 1)) ? '0 : r_idx + 1'b1;
    assign w_start   = w_accept ? w_idx_inc : r_ptr;
    assign w_ptr_d   = w_accept ? w_idx_inc : r_ptr;
    assign w_rot     = (w_cand >> w_start) | (w_cand << (int'(N) - int'(w_start)));

    // Round-robin pick: first pending entry at or above the search start, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sel   = W'((int'(w_start) + k) % int'(N));
            end
        end
    end
`else
    // Fixed-priority pick: lowest pending index.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_cand[k]) begin
                w_found = 1'b1;
                w_sel   = W'(k);
            end
        end
    end
`endif

    // Output register: hold while stalled, drop on retire of the offered entry, else reload.
    always_comb begin
        w_valid_d = r_valid;
        w_idx_d   = r_idx;
        if (r_valid && w_ret && w_ret_idx == r_idx) begin
            w_valid_d = 1'b0;
        end else if (!r_valid || w_accept) begin
            w_valid_d = w_found;
            if (w_found) w_idx_d = w_sel;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sleep <= '0;
            r_pend  <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            for (int i = 0; i < N; i++) r_wait[i] <= '0;
        end else begin
            r_sleep <= w_sleep_d;
            r_pend  <= w_pend_d;
            r_valid <= w_valid_d;
            r_idx   <= w_idx_d;
            for (int i = 0; i < N; i++) r_wait[i] <= w_wait_d[i];
        end
    end

`ifdef HNF_MSHR_WAKEUP_RR_EN
    // Round-robin pointer: one past the last accepted entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ptr <= '0;
        else     r_ptr <= w_ptr_d;
    end
`endif

    assign io_bus.mshr_sleep_entry_q      = r_sleep;
    assign io_bus.mshr_wakeup_valid_sx1_q = r_valid;
    assign io_bus.mshr_wakeup_idx_sx1_q   = r_idx;

endmodule
